// File: rtl/sym_fir_mac.sv
// sym_fir_mac: folded MAC back end of the symmetric FIR.
// One shared multiplier; round half up; saturate to WIDTH.
module sym_fir_mac #(
  parameter  int WIDTH     = 24,
  parameter  int TAP       = 101,
  parameter  int COEF_W    = 16,
  parameter  int OUT_SHIFT = 15,
  localparam int NPAIR     = (TAP - 1) / 2 + 1,
  localparam int ACC_W     = WIDTH + 1 + COEF_W + $clog2(NPAIR)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [NPAIR-1:0][WIDTH:0]    i_sum,
  input  logic [NPAIR-1:0][COEF_W-1:0] i_coef,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [WIDTH-1:0]             o_sample
);

  localparam int IW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int PW = WIDTH + 1 + COEF_W;
  localparam int RW = ACC_W + 1;
  localparam logic [IW-1:0] LAST = IW'(NPAIR - 1);
  localparam bit CENTER = (TAP % 2) == 1;
  localparam logic signed [RW-1:0] ONE  = RW'(1);
  localparam logic signed [RW-1:0] HALF = ONE <<< (OUT_SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = (ONE <<< (WIDTH - 1)) - ONE;
  localparam logic signed [RW-1:0] MINV = -MAXV - ONE;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT,
    HOLD
  } state_t;

  state_t                    state;
  logic [NPAIR-1:0][WIDTH:0] sum_q;
  logic signed [ACC_W-1:0]   acc;
  logic [IW-1:0]             idx;

  logic signed [WIDTH:0]     term;
  logic signed [COEF_W-1:0]  coef;
  logic signed [PW-1:0]      prod;
  logic signed [RW-1:0]      rsum;
  logic signed [RW-1:0]      rsh;
  logic [WIDTH-1:0]          sat;

  // current pair term times its coefficient; center entry is doubled upstream
  always_comb begin
    term = $signed(sum_q[idx]);
    if (CENTER && idx == LAST) begin
      term = term >>> 1;
    end
    coef = $signed(i_coef[idx]);
    prod = term * coef;
  end

  // round half up, drop fraction bits, clamp to the sample range
  always_comb begin
    rsum = RW'(acc) + HALF;
    rsh  = rsum >>> OUT_SHIFT;
    if (rsh > MAXV) begin
      sat = MAXV[WIDTH-1:0];
    end else if (rsh < MINV) begin
      sat = MINV[WIDTH-1:0];
    end else begin
      sat = rsh[WIDTH-1:0];
    end
  end

  // accept, multiply-accumulate one pair per clock, emit, hold for handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      sum_q    <= '0;
      acc      <= '0;
      idx      <= '0;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_sample <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            sum_q   <= i_sum;
            acc     <= '0;
            idx     <= '0;
            o_ready <= 1'b0;
            state   <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + IW'(1);
          if (idx == LAST) begin
            state <= OUT;
          end
        end
        OUT: begin
          o_sample <= sat;
          o_valid  <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_fir_mac.sv
// tb_sym_fir_mac: directed scoreboard bench for sym_fir_mac.
// Covers TAP=5, TAP=4 and the default 101-tap build.
module tb_sym_fir_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic rst_n;
  logic rstd_n;

  logic             v5, rdy5, vld5, r5;
  logic [2:0][24:0] s5;
  logic [2:0][15:0] c5;
  logic [23:0]      smp5;

  logic             v4, rdy4, vld4, r4;
  logic [1:0][24:0] s4;
  logic [1:0][15:0] c4;
  logic [23:0]      smp4;

  logic              vd, rdyd, vldd, rd;
  logic [50:0][24:0] sd;
  logic [50:0][15:0] cd;
  logic [23:0]       smpd;

  longint q5[$];
  longint mc[51];
  longint ms[51];

  sym_fir_mac #(.TAP(5)) u5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v5), .o_ready(rdy5),
    .i_sum(s5), .i_coef(c5), .o_valid(vld5), .i_ready(r5),
    .o_sample(smp5)
  );

  sym_fir_mac #(.TAP(4)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .o_ready(rdy4),
    .i_sum(s4), .i_coef(c4), .o_valid(vld4), .i_ready(r4),
    .o_sample(smp4)
  );

  sym_fir_mac ud (
    .i_clk(clk), .i_rst_n(rstd_n), .i_valid(vd), .o_ready(rdyd),
    .i_sum(sd), .i_coef(cd), .o_valid(vldd), .i_ready(rd),
    .o_sample(smpd)
  );

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(int tap, int np);
    longint acc;
    longint t;
    longint r;
    acc = 0;
    for (int k = 0; k < np; k++) begin
      t = ms[k];
      if ((tap % 2) == 1 && k == np - 1) t = t / 2;
      acc += mc[k] * t;
    end
    r = (acc + 16384) >>> 15;
    if (r > 8388607) r = 8388607;
    if (r < -8388608) r = -8388608;
    return r;
  endfunction

  task automatic send5(input longint a0, input longint a1,
                       input longint a2, input longint k0,
                       input longint k1, input longint k2,
                       input longint e);
    int n = 0;
    while (!rdy5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send5_ready", longint'(rdy5), 1);
    s5[0] = 25'(a0); s5[1] = 25'(a1); s5[2] = 25'(a2);
    c5[0] = 16'(k0); c5[1] = 16'(k1); c5[2] = 16'(k2);
    v5 = 1'b1;
    @(posedge clk); #1;
    v5 = 1'b0;
    q5.push_back(e);
  endtask

  task automatic recv5(input int lat, input string tag);
    int n = 0;
    longint e;
    while (!vld5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (lat > 0) chk({tag, "_lat"}, longint'(n), longint'(lat));
    if (q5.size() > 0) e = q5.pop_front();
    else e = 64'sd999999999;
    chk(tag, longint'($signed(smp5)), e);
    r5 = 1'b1;
    @(posedge clk); #1;
    r5 = 1'b0;
    chk({tag, "_vld_low"}, longint'(vld5), 0);
    chk({tag, "_rdy"}, longint'(rdy5), 1);
  endtask

  initial begin
    int n;
    int seen;
    longint e;
    rst_n = 1'b0; rstd_n = 1'b0;
    v5 = 0; r5 = 0; s5 = '0; c5 = '0;
    v4 = 0; r4 = 0; s4 = '0; c4 = '0;
    vd = 0; rd = 0; sd = '0; cd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", longint'(vld5), 0);
    chk("rst_smp", longint'(smp5), 0);
    rst_n = 1'b1; rstd_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_rdy5", longint'(rdy5), 1);
    chk("rel_rdyd", longint'(rdyd), 1);
    chk("rel_vldd", longint'(vldd), 0);

    send5(1000, 0, 0, 16384, 0, 0, 500);
    recv5(4, "basic");
    send5(0, 0, 1600, 0, 0, 16384, 400);
    recv5(4, "center5");

    s4[1] = 25'(1600); c4[1] = 16'(16384);
    v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    n = 0;
    while (!vld4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("even4_lat", longint'(n), 3);
    chk("even4", longint'($signed(smp4)), 800);
    r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0;
    chk("even4_rdy", longint'(rdy4), 1);

    send5(16777215, 16777215, 16777215, 32767, 32767, 32767, 8388607);
    recv5(4, "sat_pos");
    send5(-16777216, -16777216, -16777216, 32767, 32767, 32767,
          -8388608);
    recv5(4, "sat_neg");
    send5(3, 0, 0, 16384, 0, 0, 2);
    recv5(4, "rnd_pos");
    send5(-3, 0, 0, 16384, 0, 0, -1);
    recv5(4, "rnd_neg");

    send5(1000, 0, 0, 16384, 0, 0, 500);
    n = 0;
    while (!vld5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", longint'(n), 4);
    s5[0] = 25'(2000);
    v5 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_vld", longint'(vld5), 1);
      chk("bp_smp", longint'($signed(smp5)), 500);
      chk("bp_rdy", longint'(rdy5), 0);
    end
    if (q5.size() > 0) e = q5.pop_front();
    else e = 64'sd999999999;
    chk("bp_first", longint'($signed(smp5)), e);
    r5 = 1'b1;
    @(posedge clk); #1;
    r5 = 1'b0;
    chk("bp_hs_vld", longint'(vld5), 0);
    chk("bp_hs_rdy", longint'(rdy5), 1);
    @(posedge clk); #1;
    v5 = 1'b0;
    q5.push_back(1000);
    chk("bp_accept", longint'(rdy5), 0);
    recv5(4, "bp_second");

    for (int k = 0; k < 51; k++) begin
      mc[k] = longint'($urandom_range(2000)) - 1000;
      ms[k] = longint'($urandom_range(8000000)) - 4000000;
    end
    ms[50] = 2 * (ms[50] / 2);
    mc[0] = 1000; ms[0] = 4000000;
    for (int k = 0; k < 51; k++) begin
      sd[k] = 25'(ms[k]);
      cd[k] = 16'(mc[k]);
    end
    e = model(101, 51);
    vd = 1'b1;
    @(posedge clk); #1;
    vd = 1'b0;
    n = 0;
    while (!vldd && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dflt_lat", longint'(n), 52);
    chk("dflt_smp", longint'($signed(smpd)), e);
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;

    vd = 1'b1;
    @(posedge clk); #1;
    vd = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstd_n = 1'b0;
    #1;
    chk("mid_rst_vld", longint'(vldd), 0);
    chk("mid_rst_smp", longint'(smpd), 0);
    #2;
    rstd_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rdy", longint'(rdyd), 1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (vldd) seen++;
    end
    chk("mid_rst_noout", longint'(seen), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
